mem_io_ctrl: RTL and testbench
==============================

Name: mem_io_ctrl

Overview:
- Parametrised memory/IO front end placed between the CPU datapath, the dual-port block RAM and the VGA/PS2 peripherals.
- Muxes the instruction-fetch and data addresses onto RAM port A.
- Decodes memory-mapped keyboard data and status registers, backed by a scancode FIFO, so keypresses are never lost between CPU polls.
- Drives RAM port B with the framebuffer row address derived incrementally from vcount.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 10, RAM address width
- KB_DEPTH, 8, scancode FIFO depth (power of two, ≥2)
- ROWS, 20, framebuffer rows
- ROW_H, 24, scanlines per row
- FB_TOP, 1022, RAM address of row 0; row r lives at FB_TOP-r
- KB_DATA_ADDR, 1023, keyboard data register address
- KB_STAT_ADDR, 1002, keyboard status register address

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc_addr  in  ADDR_W  instruction fetch address
- data_addr  in  ADDR_W  load/store address
- fetch_sel  in  1  1: port A uses pc_addr; 0: port A uses data_addr
- cpu_din  in  DATA_W  store data
- cpu_wen  in  1  store strobe (honoured only when fetch_sel=0)
- cpu_dout  out  DATA_W  read data, one cycle after the request
- ram_addr_a  out  ADDR_W  RAM port A address
- ram_din_a  out  DATA_W  RAM port A write data
- ram_wen_a  out  1  RAM port A write enable
- ram_dout_a  in  DATA_W  RAM port A read data (synchronous read, 1 cycle)
- ram_addr_b  out  ADDR_W  RAM port B address (video, read-only)
- vcount  in  10  current VGA scanline
- vid_row_valid  out  1  1 while vcount is inside the ROWS*ROW_H region
- kb_byte  in  8  scancode byte, already synchronised to clk
- kb_valid  in  1  one-cycle strobe marking kb_byte valid
- key_last  out  8  last byte pushed (debug LEDs)
- kb_overflow  out  1  sticky overflow flag

Behaviour:
- Reset values:
  - cpu_dout=0, ram_addr_b=FB_TOP, vid_row_valid=1, key_last=0, kb_overflow=0.
  - FIFO empty; row index 0; row boundary ROW_H.
- Port A:
  - ram_addr_a is combinational: fetch_sel ? pc_addr : data_addr.
  - ram_din_a=cpu_din.
  - ram_wen_a = cpu_wen & ~fetch_sel & addr not in {KB_DATA_ADDR, KB_STAT_ADDR}. MMIO addresses never write RAM.
- Read path:
  - The address-class select (RAM, KBDATA, KBSTAT) is registered on posedge and muxes cpu_dout in the following cycle.
  - RAM reads therefore return in 1 cycle.
- KBDATA read (fetch_sel=0, cpu_wen=0, data_addr=KB_DATA_ADDR):
  - Returns {0, head byte} next cycle and pops one entry.
  - If the FIFO is empty, returns 0 and performs no pop.
- KBSTAT read:
  - Returns status next cycle: bit0 = empty, bit1 = overflow, bits[1+CNT_W:2] = occupancy count; all other bits 0.
  - The status value is the one sampled at the request edge.
- KBSTAT write with cpu_din[1]=1 clears kb_overflow. Writes to KBDATA are ignored.
- FIFO push on kb_valid; key_last <= kb_byte on every kb_valid.
- Full, push without pop: byte dropped; kb_overflow set (sticky until cleared or reset).
- Full, push and pop in the same cycle: both occur; count unchanged; no overflow.
- Empty, push and pop in the same cycle: the pop returns 0 and the pushed byte is stored. There is no bypass.
- Overflow set and clear in the same cycle: set wins.
- Pointers wrap modulo KB_DEPTH; count is ADDR-independent, width CNT_W = log2(KB_DEPTH)+1.
- Video row tracker, registered, evaluated every clk:
  - vcount==0 or vcount < previous vcount: row=0, boundary=ROW_H.
  - Else if vcount > boundary and row < ROWS: row += 1, boundary += ROW_H.
  - Row r therefore covers vcount (r*ROW_H, (r+1)*ROW_H], with row 0 also covering vcount 0.
  - vcount must advance by at most ROW_H per clk.
- Video outputs, registered one cycle after row update:
  - ram_addr_b = FB_TOP - row when row < ROWS, else FB_TOP.
  - vid_row_valid = (row < ROWS).
  - Pixel data at RAM port B is thus valid 2 cycles after the vcount change.
- Reset mid-operation: all state clears immediately; a FIFO pop in flight is lost; cpu_dout=0.

Decomposition:
- Package mem_io_pkg: default address constants, status bit positions (STAT_EMPTY=0, STAT_OVF=1, STAT_CNT_LSB=2) and the address-class enum {SEL_RAM, SEL_KBDATA, SEL_KBSTAT}.
- One sub-module, scancode_fifo: parameter DEPTH; ports clk, reset, push, din[7:0], pop, dout[7:0], empty, full, count, overflow, ovf_clr.
- Row tracker and decode stay in the top level.

Test Plan:
- Reset, then fetch_sel=1, pc_addr=5 with RAM[5]=16'hBEEF -> ram_addr_a=5 and cpu_dout=16'hBEEF one cycle later. Also ram_wen_a=0 even with cpu_wen=1.
- Push 0x1C, 0x32, then read KBDATA twice, then a third time -> cpu_dout=0x001C, then 0x0032, then 0x0000. KBSTAT then reads 0x0001.
- Push 9 bytes with KB_DEPTH=8 -> KBSTAT reads 0x0022 (count 8, overflow). First pop returns byte 1; the 9th byte is absent; key_last equals byte 9.
- FIFO full, push and KBDATA read in the same cycle -> count stays 8, overflow stays 0. Then write KBSTAT with 0x0002 after forcing an overflow -> overflow cleared.
- Sweep vcount 0..525 -> ram_addr_b=1022 for vcount 0..24 and 1021 for 25..48. Reaches 1003 at 457..480; vcount>480 gives vid_row_valid=0. vcount wrap to 0 gives 1022 again.
- Assert reset with 3 entries queued and a KBDATA read pending -> cpu_dout=0, KBSTAT=0x0001 after release, key_last=0.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared constants and types for the CPU memory/IO front end.
// Holds default MMIO addresses, status-register bit positions and the read-class select.
package mem_io_pkg;

    localparam int unsigned DEF_FB_TOP       = 1022;
    localparam int unsigned DEF_KB_DATA_ADDR = 1023;
    localparam int unsigned DEF_KB_STAT_ADDR = 1002;

    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_OVF     = 1;
    localparam int unsigned STAT_CNT_LSB = 2;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_KBDATA,
        SEL_KBSTAT
    } addr_sel_e;

endpackage

// File: rtl/mem_io_ctrl_scancode_fifo.sv
// Scancode FIFO: keyboard bytes queued between CPU polls, with a sticky overflow flag.
// A pop on an empty FIFO returns 0; there is no push-to-pop bypass.
module scancode_fifo #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             ovf_clr
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop, drop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign count    = cnt_q;
    assign overflow = ovf_q;
    assign dout     = empty ? '0 : mem_q[rd_q];

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        wr_d  = wr_q + PTR_W'(do_push);
        rd_d  = rd_q + PTR_W'(do_pop);
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU memory/IO front end: port A mux with keyboard MMIO decode, scancode FIFO,
// and the video row tracker that drives the framebuffer address on port B.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned KB_DEPTH     = 8,
    parameter int unsigned ROWS         = 20,
    parameter int unsigned ROW_H        = 24,
    parameter int unsigned FB_TOP       = DEF_FB_TOP,
    parameter int unsigned KB_DATA_ADDR = DEF_KB_DATA_ADDR,
    parameter int unsigned KB_STAT_ADDR = DEF_KB_STAT_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              fetch_sel,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_wen,
    output logic [DATA_W-1:0] cpu_dout,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_din_a,
    output logic              ram_wen_a,
    input  logic [DATA_W-1:0] ram_dout_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [9:0]        vcount,
    output logic              vid_row_valid,
    input  logic [7:0]        kb_byte,
    input  logic              kb_valid,
    output logic [7:0]        key_last,
    output logic              kb_overflow
);

    localparam int unsigned CNT_W   = $clog2(KB_DEPTH) + 1;
    localparam int unsigned ROW_W   = $clog2(ROWS + 1);
    localparam int unsigned BND_RAW = $clog2((ROWS + 1) * ROW_H + 1);
    localparam int unsigned BND_W   = (BND_RAW > 10) ? BND_RAW : 11;

    logic              is_kbd, is_kbs, kb_pop, ovf_clr;
    logic [7:0]        fifo_dout;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    addr_sel_e         sel_q, sel_d;
    logic [DATA_W-1:0] kbd_q, kbd_d;
    logic [DATA_W-1:0] stat_q, stat_d;
    logic              live_q;
    logic [7:0]        key_last_q;

    logic [ROW_W-1:0]  row_q, row_d;
    logic [BND_W-1:0]  bound_q, bound_d;
    logic [9:0]        vprev_q;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic              valid_q, valid_d;

    assign is_kbd  = ~fetch_sel & (data_addr == ADDR_W'(KB_DATA_ADDR));
    assign is_kbs  = ~fetch_sel & (data_addr == ADDR_W'(KB_STAT_ADDR));
    assign kb_pop  = is_kbd & ~cpu_wen;
    assign ovf_clr = is_kbs & cpu_wen & cpu_din[STAT_OVF];

    assign ram_addr_a = fetch_sel ? pc_addr : data_addr;
    assign ram_din_a  = cpu_din;
    assign ram_wen_a  = cpu_wen & ~fetch_sel & ~is_kbd & ~is_kbs;

    scancode_fifo #(
        .DEPTH (KB_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (kb_valid),
        .din      (kb_byte),
        .pop      (kb_pop),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (),
        .count    (fifo_count),
        .overflow (kb_overflow),
        .ovf_clr  (ovf_clr)
    );

    always_comb begin
        sel_d = SEL_RAM;
        if (is_kbd)      sel_d = SEL_KBDATA;
        else if (is_kbs) sel_d = SEL_KBSTAT;
        kbd_d  = kb_pop ? DATA_W'(fifo_dout) : '0;
        stat_d = '0;
        stat_d[STAT_EMPTY]                  = fifo_empty;
        stat_d[STAT_OVF]                    = kb_overflow;
        stat_d[STAT_CNT_LSB +: CNT_W]       = fifo_count;
    end

    // live_q holds cpu_dout at 0 until the first request edge after reset.
    always_comb begin
        cpu_dout = '0;
        if (live_q) begin
            unique case (sel_q)
                SEL_KBDATA: cpu_dout = kbd_q;
                SEL_KBSTAT: cpu_dout = stat_q;
                default:    cpu_dout = ram_dout_a;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q      <= SEL_RAM;
            kbd_q      <= '0;
            stat_q     <= '0;
            live_q     <= 1'b0;
            key_last_q <= '0;
        end else begin
            sel_q  <= sel_d;
            kbd_q  <= kbd_d;
            stat_q <= stat_d;
            live_q <= 1'b1;
            if (kb_valid) key_last_q <= kb_byte;
        end
    end

    assign key_last = key_last_q;

    always_comb begin
        row_d   = row_q;
        bound_d = bound_q;
        if (vcount == '0 || vcount < vprev_q) begin
            row_d   = '0;
            bound_d = BND_W'(ROW_H);
        end else if (BND_W'(vcount) > bound_q && row_q < ROW_W'(ROWS)) begin
            row_d   = row_q + ROW_W'(1);
            bound_d = bound_q + BND_W'(ROW_H);
        end
        valid_d  = (row_q < ROW_W'(ROWS));
        addr_b_d = valid_d ? (ADDR_W'(FB_TOP) - ADDR_W'(row_q)) : ADDR_W'(FB_TOP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q    <= '0;
            bound_q  <= BND_W'(ROW_H);
            vprev_q  <= '0;
            addr_b_q <= ADDR_W'(FB_TOP);
            valid_q  <= 1'b1;
        end else begin
            row_q    <= row_d;
            bound_q  <= bound_d;
            vprev_q  <= vcount;
            addr_b_q <= addr_b_d;
            valid_q  <= valid_d;
        end
    end

    assign ram_addr_b    = addr_b_q;
    assign vid_row_valid = valid_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl with a behavioural dual-port RAM.
module tb_mem_io_ctrl;

    localparam logic [9:0] KBD = 10'd1023;
    localparam logic [9:0] KBS = 10'd1002;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pc_addr, data_addr;
    logic        fetch_sel;
    logic [15:0] cpu_din;
    logic        cpu_wen;
    logic [15:0] cpu_dout;
    logic [9:0]  ram_addr_a;
    logic [15:0] ram_din_a;
    logic        ram_wen_a;
    logic [15:0] ram_dout_a = '0;
    logic [9:0]  ram_addr_b;
    logic [9:0]  vcount;
    logic        vid_row_valid;
    logic [7:0]  kb_byte;
    logic        kb_valid;
    logic [7:0]  key_last;
    logic        kb_overflow;

    logic [15:0] mem [1024];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    string       tag_q [$];
    logic [15:0] exp_q [$];
    logic [9:0]  vaddr_q [$];
    logic        vvalid_q [$];

    always #5 clk = ~clk;

    mem_io_ctrl #(
        .DATA_W (16),
        .ADDR_W (10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .data_addr     (data_addr),
        .fetch_sel     (fetch_sel),
        .cpu_din       (cpu_din),
        .cpu_wen       (cpu_wen),
        .cpu_dout      (cpu_dout),
        .ram_addr_a    (ram_addr_a),
        .ram_din_a     (ram_din_a),
        .ram_wen_a     (ram_wen_a),
        .ram_dout_a    (ram_dout_a),
        .ram_addr_b    (ram_addr_b),
        .vcount        (vcount),
        .vid_row_valid (vid_row_valid),
        .kb_byte       (kb_byte),
        .kb_valid      (kb_valid),
        .key_last      (key_last),
        .kb_overflow   (kb_overflow)
    );

    always @(posedge clk) begin
        if (ram_wen_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_a <= mem[ram_addr_a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU/keyboard cycle; an expected read result is queued and checked after the edge.
    task automatic op(input logic fs, input logic [9:0] addr, input logic wen,
                      input logic [15:0] din, input logic kv, input logic [7:0] kb,
                      input logic expv, input logic [15:0] exp, input string tag);
        fetch_sel = fs;
        pc_addr   = addr;
        data_addr = addr;
        cpu_wen   = wen;
        cpu_din   = din;
        kb_valid  = kv;
        kb_byte   = kb;
        if (expv) begin
            tag_q.push_back(tag);
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        while (tag_q.size() > 0) begin
            string       t;
            logic [15:0] e;
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, 32'(cpu_dout), 32'(e));
        end
    endtask

    task automatic idle();
        op(1'b1, 10'd0, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 16'h0, "");
    endtask

    task automatic push_kb(input logic [7:0] b);
        op(1'b1, 10'd0, 1'b0, 16'h0, 1'b1, b, 1'b0, 16'h0, "");
    endtask

    task automatic rd(input logic [9:0] a, input logic [15:0] exp, input string tag);
        op(1'b0, a, 1'b0, 16'h0, 1'b0, 8'h0, 1'b1, exp, tag);
    endtask

    task automatic vid_step(input int v);
        int row;
        vcount = 10'(v);
        row = (v == 0) ? 0 : (v - 1) / 24;
        if (row > 20) row = 20;
        vaddr_q.push_back((row < 20) ? 10'(1022 - row) : 10'd1022);
        vvalid_q.push_back(row < 20);
        @(posedge clk);
        #1;
        if (vaddr_q.size() == 2) begin
            check("vid_addr", 32'(ram_addr_b), 32'(vaddr_q.pop_front()));
            check("vid_valid", 32'(vid_row_valid), 32'(vvalid_q.pop_front()));
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 3);
        mem[5] = 16'hBEEF;
        reset = 1'b1;
        fetch_sel = 1'b1; pc_addr = '0; data_addr = '0;
        cpu_din = '0; cpu_wen = 1'b0; kb_byte = '0; kb_valid = 1'b0; vcount = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_dout", 32'(cpu_dout), 32'h0);
        check("rst_addr_b", 32'(ram_addr_b), 32'd1022);
        check("rst_row_valid", 32'(vid_row_valid), 32'h1);
        check("rst_key_last", 32'(key_last), 32'h0);
        check("rst_overflow", 32'(kb_overflow), 32'h0);
        reset = 1'b0;
        idle();

        // Fetch path: write strobe ignored while fetching.
        fetch_sel = 1'b1; pc_addr = 10'd5; cpu_wen = 1'b1; cpu_din = 16'h5555;
        #1;
        check("fetch_addr_a", 32'(ram_addr_a), 32'd5);
        check("fetch_wen_a", 32'(ram_wen_a), 32'h0);
        op(1'b1, 10'd5, 1'b1, 16'h5555, 1'b0, 8'h0, 1'b1, 16'hBEEF, "fetch_read");
        op(1'b0, 10'd100, 1'b1, 16'h1234, 1'b0, 8'h0, 1'b0, 16'h0, "");
        rd(10'd100, 16'h1234, "ram_rw");

        // MMIO writes never reach RAM.
        fetch_sel = 1'b0; data_addr = KBD; cpu_wen = 1'b1;
        #1;
        check("mmio_wen_a", 32'(ram_wen_a), 32'h0);

        push_kb(8'h1C);
        push_kb(8'h32);
        check("key_last_2", 32'(key_last), 32'h32);
        rd(KBD, 16'h001C, "kbd_1");
        rd(KBD, 16'h0032, "kbd_2");
        rd(KBD, 16'h0000, "kbd_empty");
        rd(KBS, 16'h0001, "stat_empty");

        for (int i = 1; i <= 9; i++) push_kb(8'(8'h10 + i));
        rd(KBS, 16'h0022, "stat_ovf");
        check("ovf_flag", 32'(kb_overflow), 32'h1);
        check("key_last_9", 32'(key_last), 32'h19);
        for (int i = 1; i <= 8; i++) rd(KBD, 16'(8'h10 + i), "kbd_drain");
        rd(KBD, 16'h0000, "kbd_9th_absent");
        op(1'b0, KBS, 1'b1, 16'h0002, 1'b0, 8'h0, 1'b0, 16'h0, "");
        rd(KBS, 16'h0001, "stat_cleared");

        for (int i = 0; i < 8; i++) push_kb(8'(8'hA0 + i));
        rd(KBS, 16'h0020, "stat_full");
        op(1'b0, KBD, 1'b0, 16'h0, 1'b1, 8'hA8, 1'b1, 16'h00A0, "full_pushpop");
        rd(KBS, 16'h0020, "stat_full_pushpop");
        // Set and clear of overflow in the same cycle: set wins.
        op(1'b0, KBS, 1'b1, 16'h0002, 1'b1, 8'hEE, 1'b0, 16'h0, "");
        rd(KBS, 16'h0022, "stat_set_wins");
        op(1'b0, KBS, 1'b1, 16'h0002, 1'b0, 8'h0, 1'b0, 16'h0, "");
        rd(KBS, 16'h0020, "stat_clr");
        for (int i = 1; i <= 8; i++) rd(KBD, 16'(8'hA0 + i), "kbd_drain2");
        rd(KBS, 16'h0001, "stat_empty2");
        op(1'b0, KBD, 1'b0, 16'h0, 1'b1, 8'h5A, 1'b1, 16'h0000, "empty_pushpop");
        rd(KBS, 16'h0004, "stat_one");
        rd(KBD, 16'h005A, "kbd_nobypass");
        check("key_last_5a", 32'(key_last), 32'h5A);

        idle();
        for (int v = 0; v <= 525; v++) vid_step(v);
        for (int i = 0; i < 3; i++) vid_step(0);
        @(posedge clk);
        #1;
        check("vid_addr_end", 32'(ram_addr_b), 32'(vaddr_q.pop_front()));
        check("vid_valid_end", 32'(vid_row_valid), 32'(vvalid_q.pop_front()));

        push_kb(8'h01);
        push_kb(8'h02);
        push_kb(8'h03);
        fetch_sel = 1'b0; data_addr = KBD; cpu_wen = 1'b0; kb_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_cpu_dout", 32'(cpu_dout), 32'h0);
        check("midrst_key_last", 32'(key_last), 32'h0);
        check("midrst_overflow", 32'(kb_overflow), 32'h0);
        check("midrst_addr_b", 32'(ram_addr_b), 32'd1022);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(KBS, 16'h0001, "midrst_stat");
        rd(KBD, 16'h0000, "midrst_kbd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
